// File: rtl/adaptive_fir_mac_pkg.sv
// Shared ANC definitions: Q.10 scaling, saturation helper and the FIR/MAC state encoding.
package adaptive_fir_mac_pkg;

    // Coefficients are Q.10, so the accumulated product carries 10 fractional bits.
    localparam int unsigned QShift = 10;

    typedef enum logic [1:0] {
        StIdle,
        StMac,
        StOutput
    } state_e;

    // Clamp a wide signed value into the signed range of a w-bit word (result kept 64-bit).
    function automatic logic signed [63:0] sat_value(input logic signed [63:0] x,
                                                     input int unsigned       w);
        logic signed [63:0] hi;
        logic signed [63:0] lo;
        hi = (64'sd1 <<< (w - 1)) - 64'sd1;
        lo = -(64'sd1 <<< (w - 1));
        if (x > hi) begin
            return hi;
        end
        if (x < lo) begin
            return lo;
        end
        return x;
    endfunction

endpackage

// File: rtl/adaptive_fir_mac_if.sv
// Sample, coefficient and result bundle between a sample source and the FIR/MAC engine.
interface adaptive_fir_mac_if #(
    parameter int DATA_BUS_SIZE = 11,
    parameter int TAPS          = 3
);
    logic                                 sigEnable;
    logic signed [DATA_BUS_SIZE-1:0]      signal_I;
    logic signed [DATA_BUS_SIZE-1:0]      signal_Q;
    logic signed [DATA_BUS_SIZE-1:0]      desired_I;
    logic signed [DATA_BUS_SIZE-1:0]      desired_Q;
    logic [TAPS-1:0][DATA_BUS_SIZE-1:0]   coefficient_I;
    logic [TAPS-1:0][DATA_BUS_SIZE-1:0]   coefficient_Q;
    logic signed [DATA_BUS_SIZE-1:0]      estimate_I;
    logic signed [DATA_BUS_SIZE-1:0]      estimate_Q;
    logic signed [DATA_BUS_SIZE-1:0]      error_I;
    logic signed [DATA_BUS_SIZE-1:0]      error_Q;
    logic                                 outValid;
    logic                                 busy;
    logic                                 satFlag;
    logic [7:0]                           dropCount;

    modport master (
        output sigEnable, signal_I, signal_Q, desired_I, desired_Q,
               coefficient_I, coefficient_Q,
        input  estimate_I, estimate_Q, error_I, error_Q, outValid, busy, satFlag, dropCount
    );

    modport slave (
        input  sigEnable, signal_I, signal_Q, desired_I, desired_Q,
               coefficient_I, coefficient_Q,
        output estimate_I, estimate_Q, error_I, error_Q, outValid, busy, satFlag, dropCount
    );

endinterface

// File: rtl/ComplexMultiplyer.sv
// Full-precision complex multiplier with a registered product and a matching valid flag.
module ComplexMultiplyer #(
    parameter int A_WIDTH     = 11,
    parameter int B_WIDTH     = 11,
    parameter bit B_CONJUGATE = 1'b0,
    parameter int P_WIDTH     = A_WIDTH + B_WIDTH + 1
) (
    input  logic                      clk_i,
    input  logic                      rst_i,
    input  logic                      en_i,
    input  logic signed [A_WIDTH-1:0] a_re_i,
    input  logic signed [A_WIDTH-1:0] a_im_i,
    input  logic signed [B_WIDTH-1:0] b_re_i,
    input  logic signed [B_WIDTH-1:0] b_im_i,
    output logic signed [P_WIDTH-1:0] p_re_o,
    output logic signed [P_WIDTH-1:0] p_im_o,
    output logic                      valid_o
);

    logic signed [P_WIDTH-1:0] ar, ai, br, bi, re_d, im_d;

    // Widen operands first so the products are computed at full output width.
    always_comb begin
        ar   = P_WIDTH'(a_re_i);
        ai   = P_WIDTH'(a_im_i);
        br   = P_WIDTH'(b_re_i);
        bi   = B_CONJUGATE ? -(P_WIDTH'(b_im_i)) : P_WIDTH'(b_im_i);
        re_d = ar * br - ai * bi;
        im_d = ar * bi + ai * br;
    end

    // Product register; valid follows the enable by one cycle.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            p_re_o  <= '0;
            p_im_o  <= '0;
            valid_o <= 1'b0;
        end else begin
            valid_o <= en_i;
            if (en_i) begin
                p_re_o <= re_d;
                p_im_o <= im_d;
            end
        end
    end

endmodule

// File: rtl/adaptive_fir_mac.sv
// Complex FIR for adaptive noise cancelling: one shared multiplier, one tap per cycle,
// producing estimate y and error e = desired - y for the coefficient adaptation loop.
module adaptive_fir_mac
    import adaptive_fir_mac_pkg::*;
#(
    parameter int DATA_BUS_SIZE = 11,
    parameter int TAPS          = 3,
    parameter int ACC_GUARD     = 4   // must be >= 1 so the accumulator covers a full product
) (
    input logic              clock,
    input logic              reset,
    adaptive_fir_mac_if.slave bus
);

    localparam int unsigned W     = DATA_BUS_SIZE;
    localparam int          ProdW = 2 * DATA_BUS_SIZE + 1;
    localparam int          AccW  = 2 * DATA_BUS_SIZE + ACC_GUARD;
    localparam int          TapW  = (TAPS > 1) ? $clog2(TAPS) : 1;

    state_e                  state_q;
    logic [TapW-1:0]         tap_q;
    logic                    drain_q;
    logic signed [W-1:0]     dly_i_q  [TAPS];
    logic signed [W-1:0]     dly_q_q  [TAPS];
    logic signed [W-1:0]     coef_i_q [TAPS];
    logic signed [W-1:0]     coef_q_q [TAPS];
    logic signed [W-1:0]     des_i_q, des_q_q;
    logic signed [AccW-1:0]  acc_i_q, acc_q_q;
    logic signed [W-1:0]     est_i_q, est_q_q, err_i_q, err_q_q;
    logic                    sat_q, out_valid_q, busy_q;
    logic [7:0]              drop_q;

    logic signed [ProdW-1:0] prod_i, prod_q;
    logic                    prod_vld;

    logic signed [AccW-1:0]  sh_i, sh_q;
    logic signed [63:0]      yf_i, yf_q, ys_i, ys_q, ef_i, ef_q, es_i, es_q;
    logic                    sat_d;

    ComplexMultiplyer #(
        .A_WIDTH    (DATA_BUS_SIZE),
        .B_WIDTH    (DATA_BUS_SIZE),
        .B_CONJUGATE(1'b0),
        .P_WIDTH    (ProdW)
    ) u_cmul (
        .clk_i  (clock),
        .rst_i  (reset),
        .en_i   (state_q == StMac),
        .a_re_i (coef_i_q[tap_q]),
        .a_im_i (coef_q_q[tap_q]),
        .b_re_i (dly_i_q[tap_q]),
        .b_im_i (dly_q_q[tap_q]),
        .p_re_o (prod_i),
        .p_im_o (prod_q),
        .valid_o(prod_vld)
    );

    // Scale the accumulator back to sample units, saturate y, then form the saturated error.
    always_comb begin
        sh_i  = acc_i_q >>> QShift;
        sh_q  = acc_q_q >>> QShift;
        yf_i  = 64'(sh_i);
        yf_q  = 64'(sh_q);
        ys_i  = sat_value(yf_i, W);
        ys_q  = sat_value(yf_q, W);
        ef_i  = 64'(des_i_q) - ys_i;
        ef_q  = 64'(des_q_q) - ys_q;
        es_i  = sat_value(ef_i, W);
        es_q  = sat_value(ef_q, W);
        sat_d = (ys_i != yf_i) || (ys_q != yf_q) || (es_i != ef_i) || (es_q != ef_q);
    end

    // Control FSM with the delay line, snapshots, accumulator and registered outputs.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q     <= StIdle;
            tap_q       <= '0;
            drain_q     <= 1'b0;
            des_i_q     <= '0;
            des_q_q     <= '0;
            acc_i_q     <= '0;
            acc_q_q     <= '0;
            est_i_q     <= '0;
            est_q_q     <= '0;
            err_i_q     <= '0;
            err_q_q     <= '0;
            sat_q       <= 1'b0;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            drop_q      <= '0;
            for (int k = 0; k < TAPS; k++) begin
                dly_i_q[k]  <= '0;
                dly_q_q[k]  <= '0;
                coef_i_q[k] <= '0;
                coef_q_q[k] <= '0;
            end
        end else begin
            out_valid_q <= 1'b0;

            // Strobes arriving outside IDLE are lost; count them for diagnostics.
            if (bus.sigEnable && (state_q != StIdle) && (drop_q != 8'hFF)) begin
                drop_q <= drop_q + 8'd1;
            end

            // Products land one cycle after issue, so accumulation trails the tap index.
            if (prod_vld) begin
                acc_i_q <= acc_i_q + AccW'(prod_i);
                acc_q_q <= acc_q_q + AccW'(prod_q);
            end

            unique case (state_q)
                StIdle: begin
                    if (bus.sigEnable) begin
                        for (int k = TAPS - 1; k > 0; k--) begin
                            dly_i_q[k] <= dly_i_q[k-1];
                            dly_q_q[k] <= dly_q_q[k-1];
                        end
                        dly_i_q[0] <= bus.signal_I;
                        dly_q_q[0] <= bus.signal_Q;
                        for (int k = 0; k < TAPS; k++) begin
                            coef_i_q[k] <= $signed(bus.coefficient_I[k]);
                            coef_q_q[k] <= $signed(bus.coefficient_Q[k]);
                        end
                        des_i_q <= bus.desired_I;
                        des_q_q <= bus.desired_Q;
                        acc_i_q <= '0;
                        acc_q_q <= '0;
                        tap_q   <= '0;
                        busy_q  <= 1'b1;
                        state_q <= StMac;
                    end
                end
                StMac: begin
                    if (tap_q == TapW'(TAPS - 1)) begin
                        drain_q <= 1'b0;
                        state_q <= StOutput;
                    end else begin
                        tap_q <= tap_q + 1'b1;
                    end
                end
                StOutput: begin
                    // First cycle lets the last product reach the accumulator.
                    if (!drain_q) begin
                        drain_q <= 1'b1;
                    end else begin
                        est_i_q     <= ys_i[W-1:0];
                        est_q_q     <= ys_q[W-1:0];
                        err_i_q     <= es_i[W-1:0];
                        err_q_q     <= es_q[W-1:0];
                        sat_q       <= sat_d;
                        out_valid_q <= 1'b1;
                        busy_q      <= 1'b0;
                        state_q     <= StIdle;
                    end
                end
                default: begin
                    state_q <= StIdle;
                end
            endcase
        end
    end

    assign bus.estimate_I = est_i_q;
    assign bus.estimate_Q = est_q_q;
    assign bus.error_I    = err_i_q;
    assign bus.error_Q    = err_q_q;
    assign bus.outValid   = out_valid_q;
    assign bus.busy       = busy_q;
    assign bus.satFlag    = sat_q;
    assign bus.dropCount  = drop_q;

endmodule

// File: doc/adaptive_fir_mac.md
ADAPTIVE_FIR_MAC -- requirements
Module: adaptive_fir_mac

Interface
REQ-001 SHALL have parameter DATA_BUS_SIZE, default 11, sample/coefficient width (signed, two's complement).
REQ-002 SHALL have parameter TAPS, default 3, filter length (>=1).
REQ-003 SHALL have parameter ACC_GUARD, default 4, accumulator guard bits.
REQ-004 SHALL have port clock  in  1  single clock; all logic on rising edge.
REQ-005 SHALL have port reset  in  1  synchronous, active-high reset.
REQ-006 SHALL have port sigEnable  in  1  new-sample strobe, one cycle per sample.
REQ-007 SHALL have ports signal_I, signal_Q  in  DATA_BUS_SIZE  reference-noise sample.
REQ-008 SHALL have ports desired_I, desired_Q  in  DATA_BUS_SIZE  primary (noisy) sample, time-aligned with signal.
REQ-009 SHALL have ports coefficient_I, coefficient_Q  in  DATA_BUS_SIZE x TAPS  current filter weights, Q.10.
REQ-010 SHALL have ports estimate_I, estimate_Q  out  DATA_BUS_SIZE  filter output y.
REQ-011 SHALL have ports error_I, error_Q  out  DATA_BUS_SIZE  e = desired - y, fed to coefficient adaptation.
REQ-012 SHALL have port outValid  out  1  one-cycle pulse when estimate/error update.
REQ-013 SHALL have port busy  out  1  high while a sample is being processed.
REQ-014 SHALL have port satFlag  out  1  high with outValid if estimate or error saturated.
REQ-015 SHALL have port dropCount  out  8  saturating count of strobes ignored while busy.

Function
REQ-016 SHALL implement FSM IDLE -> MAC -> OUTPUT -> IDLE.
REQ-017 In IDLE, sigEnable SHALL shift signal into delay line (index 0 newest, index TAPS-1 discarded), snapshot all coefficients and desired, clear accumulator, set tap index 0, go to MAC.
REQ-018 MAC SHALL spend exactly TAPS cycles, one tap per cycle, using one shared complex multiplier: acc += coef[k] * delay[k] (non-conjugate).
REQ-019 Accumulator width SHALL be 2*DATA_BUS_SIZE+ACC_GUARD per rail, full precision, no intermediate rounding.
REQ-020 OUTPUT SHALL compute y = acc arithmetic-shift-right 10 (floor), saturate to DATA_BUS_SIZE signed range, then e = desired_snapshot - y with full-width subtract and saturation.
REQ-021 outValid SHALL pulse the cycle estimate/error registers load; latency sigEnable-to-outValid = TAPS+2 cycles.
REQ-022 estimate/error/satFlag SHALL hold until next outValid.
REQ-023 busy SHALL be high in MAC and OUTPUT, low in IDLE; sigEnable while busy SHALL be ignored (no shift) and increment dropCount, saturating at 255.
REQ-024 Coefficient inputs changing during MAC SHALL have no effect on the current result (snapshot only).
REQ-025 sigEnable in the same cycle outValid returns to IDLE SHALL not be accepted (FSM is in OUTPUT); it counts as a drop.

Reset
REQ-026 reset SHALL force IDLE and zero delay line, snapshots, accumulator, estimate, error, satFlag, outValid, busy, dropCount.
REQ-027 reset mid-operation SHALL abandon the sample with no outValid; reset has priority over sigEnable.

Structure
REQ-028 Q.10 shift constant, saturate function and FSM state enum SHALL live in the shared ANC package.
REQ-029 The complex multiply SHALL reuse the existing ComplexMultiplyer sub-module with B_CONJUGATE=0 at full product width.

Verification
REQ-030 coef[0]=512+0j, others 0; signal 200+0j, desired 100+0j -> outValid at cycle 5, estimate 100+0j, error 0+0j, satFlag 0.
REQ-031 coef[0]=0+512j; signal 100+50j, desired 0 -> estimate -25+50j, error 25-50j.
REQ-032 all coef 1023+0j; three samples 1023+0j, desired 0 -> third result estimate 1023, error -1023, satFlag 1.
REQ-033 sigEnable at cycles 0 and 1 -> dropCount 1, only one delay shift, single outValid at cycle 5.
REQ-034 reset asserted at cycle 2 after sigEnable -> busy 0 next cycle, all outputs 0, no outValid.
REQ-035 coefficients changed at cycle 2 during MAC -> result matches cycle-0 coefficients.
